regfile_mp: RTL and testbench

Parametrised two-read, two-write register file for the core datapath. It is the generalised successor of the 16×16 single-write register file. It adds configurable width and depth, a second write port with defined collision priority, an optional hardwired-zero entry, and a self-clearing initialisation sequencer with a `ready` flag. An optional write-to-read bypass is also available.

---
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised 2R/2W register file with self-clearing init sequencer
// Optional same-edge write-to-read bypass enabled by REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_1,
  input  logic [ADDR_W-1:0] rd_2,
  input  logic [ADDR_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_a_data,
  input  logic              wr_a_en,
  input  logic [ADDR_W-1:0] wr_b,
  input  logic [DATA_W-1:0] wr_b_data,
  input  logic              wr_b_en,
  output logic [DATA_W-1:0] rd_1_data,
  output logic [DATA_W-1:0] rd_2_data,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic              init_we, we_a, we_b;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Writes are only qualified in RUN and are dropped on the clr edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    init_we  = 1'b0;
    we_a     = 1'b0;
    we_b     = 1'b0;
    case (state)
      S_INIT: begin
        init_we = rst_n && !is_zero(cnt);
        cnt_nx  = cnt + 1'b1;
        if (cnt == {ADDR_W{1'b1}}) state_nx = S_RUN;
      end
      S_RUN: begin
        if (clr) begin
          state_nx = S_INIT;
          cnt_nx   = '0;
        end else begin
          we_a = rst_n && wr_a_en && !is_zero(wr_a);
          we_b = rst_n && wr_b_en && !is_zero(wr_b);
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  // Port B is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (init_we) mem[cnt] <= '0;
    if (we_a) mem[wr_a] <= wr_a_data;
    if (we_b) mem[wr_b] <= wr_b_data;
  end

  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] addr);
    if (is_zero(addr)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we_b && (wr_b == addr)) return wr_b_data;
    if (we_a && (wr_a == addr)) return wr_a_data;
`endif
    return mem[addr];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_1_data <= '0;
      rd_2_data <= '0;
    end else if (state == S_RUN) begin
      rd_1_data <= rd_val(rd_1);
      rd_2_data <= rd_val(rd_2);
    end else begin
      rd_1_data <= '0;
      rd_2_data <= '0;
    end
  end

  assign ready = (state == S_RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [3:0]  rd_1, rd_2, wr_a, wr_b;
  logic [15:0] wr_a_data, wr_b_data;
  logic        wr_a_en, wr_b_en;
  logic [15:0] rd_1_data, rd_2_data;
  logic        ready;

  int checks = 0;
  int errors = 0;
  int n;

  regfile_mp #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .rd_1      (rd_1),
    .rd_2      (rd_2),
    .wr_a      (wr_a),
    .wr_a_data (wr_a_data),
    .wr_a_en   (wr_a_en),
    .wr_b      (wr_b),
    .wr_b_data (wr_b_data),
    .wr_b_en   (wr_b_en),
    .rd_1_data (rd_1_data),
    .rd_2_data (rd_2_data),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic count_to_ready(output int edges);
    edges = 0;
    while (!ready && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    rd_1 = '0; rd_2 = '0;
    wr_a = '0; wr_a_data = '0; wr_a_en = 1'b0;
    wr_b = '0; wr_b_data = '0; wr_b_en = 1'b0;

    // Reset and INIT with a write that must be ignored
    tick(); tick();
    check("reset_ready", ready, 0);
    check("reset_rd1", rd_1_data, 16'h0000);
    check("reset_rd2", rd_2_data, 16'h0000);
    rst_n = 1'b1;
    wr_a_en = 1'b1; wr_a = 4'd3; wr_a_data = 16'hAAAA; rd_1 = 4'd3;
    count_to_ready(n);
    wr_a_en = 1'b0;
    check("init_len", n, 16);
    check("init_rd1_zero", rd_1_data, 16'h0000);
    tick();
    check("init_write_ignored", rd_1_data, 16'h0000);

    // Basic write/read
    wr_a_en = 1'b1; wr_a = 4'd5; wr_a_data = 16'h1234;
    tick();
    wr_a_en = 1'b0; rd_1 = 4'd5; rd_2 = 4'd5;
    tick();
    check("basic_rd1", rd_1_data, 16'h1234);
    check("basic_rd2", rd_2_data, 16'h1234);

    // Collision: port B wins
    wr_a_en = 1'b1; wr_a = 4'd7; wr_a_data = 16'h1111;
    wr_b_en = 1'b1; wr_b = 4'd7; wr_b_data = 16'h2222;
    tick();
    wr_a_en = 1'b0; wr_b_en = 1'b0; rd_1 = 4'd7;
    tick();
    check("collision", rd_1_data, 16'h2222);

    // Independent addresses on both write ports
    wr_a_en = 1'b1; wr_a = 4'd10; wr_a_data = 16'h00AA;
    wr_b_en = 1'b1; wr_b = 4'd11; wr_b_data = 16'h00BB;
    tick();
    wr_a_en = 1'b0; wr_b_en = 1'b0; rd_1 = 4'd10; rd_2 = 4'd11;
    tick();
    check("dual_a", rd_1_data, 16'h00AA);
    check("dual_b", rd_2_data, 16'h00BB);

    // Zero register
    wr_a_en = 1'b1; wr_a = 4'd0; wr_a_data = 16'hFFFF;
    wr_b_en = 1'b1; wr_b = 4'd0; wr_b_data = 16'hFFFF;
    rd_1 = 4'd0; rd_2 = 4'd0;
    tick();
    check("zero_same_edge", rd_1_data, 16'h0000);
    wr_a_en = 1'b0; wr_b_en = 1'b0;
    tick();
    check("zero_after", rd_2_data, 16'h0000);

    // Same-edge read/write: bypass vs read-before-write
    wr_a_en = 1'b1; wr_a = 4'd9; wr_a_data = 16'h0042;
    tick();
    wr_a_data = 16'hBEEF; rd_1 = 4'd9;
    tick();
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_edge", rd_1_data, 16'hBEEF);
`else
    check("rbw_same_edge", rd_1_data, 16'h0042);
`endif
    wr_a_en = 1'b0;
    tick();
    check("rbw_next", rd_1_data, 16'hBEEF);

    // clr in RUN: concurrent write dropped, file cleared
    wr_a_en = 1'b1; wr_a = 4'd2; wr_a_data = 16'h5555;
    tick();
    wr_a = 4'd4; wr_a_data = 16'h7777; clr = 1'b1; rd_1 = 4'd2;
    tick();
    clr = 1'b0; wr_a_en = 1'b0;
    check("clr_ready_low", ready, 0);
    check("clr_edge_read", rd_1_data, 16'h5555);
    count_to_ready(n);
    check("clr_len", n, 16);
    tick();
    check("clr_reg2", rd_1_data, 16'h0000);
    rd_1 = 4'd4;
    tick();
    check("clr_dropped_write", rd_1_data, 16'h0000);

    // Reset mid-INIT, with clr held during the following INIT
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mid_init_ready", ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; clr = 1'b1;
    count_to_ready(n);
    clr = 1'b0;
    check("reinit_len", n, 16);
    rd_1 = 4'd5; rd_2 = 4'd7;
    tick();
    check("reinit_rd1", rd_1_data, 16'h0000);
    check("reinit_rd2", rd_2_data, 16'h0000);
    check("reinit_ready", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
